simon64_96_cbc: RTL and testbench

Sequential CBC-mode controller for SIMON64/96 block encryption and decryption. It accepts 64-bit blocks over a valid/ready handshake and latches the key and IV. It feeds each block, pre-whitened with the chaining value, into one instance of the combinational `simon64_96` core, then registers the result (post-whitened on decrypt). It sits directly upstream and downstream of the cipher core, acting as the streaming front end between the bus interface and the core.

---
 rtl/simon_cbc_pkg.sv | 23 ++
 rtl/simon64_96_cbc_if.sv | 22 ++
 rtl/simon64_96.sv | 78 +++++++
 rtl/simon64_96_cbc.sv | 149 ++++++++++++++
 tb/tb_simon64_96_cbc.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_cbc_pkg.sv
// Shared types and constants for the SIMON64/96 CBC controller and its cipher core.
package simon_cbc_pkg;

    localparam int unsigned BLK_W  = 64;
    localparam int unsigned KEY_W  = 96;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ROUNDS = 42;

    // z2 constant sequence, first element in the MSB.
    localparam logic [61:0] Z2_SEQ =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    typedef enum logic [1:0] {
        UNKEYED = 2'd0,
        IDLE    = 2'd1,
        CALC    = 2'd2,
        OUT     = 2'd3
    } cbc_state_t;

endpackage

// File: rtl/simon64_96_cbc_if.sv
// Block stream handshake between a producer/consumer and the CBC controller.
interface simon64_96_cbc_if;
    import simon_cbc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/simon64_96.sv
// Combinational SIMON64/96 block cipher: full 42-round key schedule and datapath.
module simon64_96
    import simon_cbc_pkg::*;
(
    input  logic [BLK_W-1:0] block_in,
    input  logic [KEY_W-1:0] key,
    input  logic             encryptOrDecrypt,
    output logic [BLK_W-1:0] block_out
);

    localparam int unsigned KS_W = ROUNDS * WORD_W;

    function automatic logic [WORD_W-1:0] f_rnd(input logic [WORD_W-1:0] x);
        return ({x[30:0], x[31]} & {x[23:0], x[31:24]}) ^ {x[29:0], x[31:30]};
    endfunction

    // Round keys packed with k0 in the low word and k41 in the high word.
    function automatic logic [KS_W-1:0] key_sched(input logic [KEY_W-1:0] k);
        logic [WORD_W-1:0] a, b, c, t;
        logic [61:0]       z;
        logic [KS_W-1:0]   ks;
        a  = k[31:0];
        b  = k[63:32];
        c  = k[95:64];
        z  = Z2_SEQ;
        ks = '0;
        for (int unsigned i = 0; i < ROUNDS; i++) begin
            ks = {a, ks[KS_W-1:WORD_W]};
            t  = {c[2:0], c[31:3]};
            t  = t ^ {t[0], t[31:1]};
            t  = ~a ^ t ^ {30'd0, 1'b1, ~z[61]};
            z  = {z[60:0], 1'b0};
            a  = b;
            b  = c;
            c  = t;
        end
        return ks;
    endfunction

    function automatic logic [BLK_W-1:0] enc_rounds(input logic [BLK_W-1:0] blk,
                                                    input logic [KS_W-1:0]  ks_in);
        logic [WORD_W-1:0] x, y, t;
        logic [KS_W-1:0]   ks;
        x  = blk[63:32];
        y  = blk[31:0];
        ks = ks_in;
        for (int unsigned i = 0; i < ROUNDS; i++) begin
            t  = x;
            x  = y ^ f_rnd(x) ^ ks[WORD_W-1:0];
            y  = t;
            ks = ks >> WORD_W;
        end
        return {x, y};
    endfunction

    function automatic logic [BLK_W-1:0] dec_rounds(input logic [BLK_W-1:0] blk,
                                                    input logic [KS_W-1:0]  ks_in);
        logic [WORD_W-1:0] x, y, t;
        logic [KS_W-1:0]   ks;
        x  = blk[63:32];
        y  = blk[31:0];
        ks = ks_in;
        for (int unsigned i = 0; i < ROUNDS; i++) begin
            t  = y;
            y  = x ^ f_rnd(y) ^ ks[KS_W-1:KS_W-WORD_W];
            x  = t;
            ks = ks << WORD_W;
        end
        return {x, y};
    endfunction

    logic [KS_W-1:0] round_keys;

    assign round_keys = key_sched(key);
    assign block_out  = (encryptOrDecrypt == MODE_ENC) ? enc_rounds(block_in, round_keys)
                                                       : dec_rounds(block_in, round_keys);

endmodule

// File: rtl/simon64_96_cbc.sv
// CBC-mode streaming controller around one combinational simon64_96 core.
// Define SIMON_CBC_DECRYPT_EN to honour cfg_mode; otherwise the block is encrypt-only.
module simon64_96_cbc
    import simon_cbc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic [BLK_W-1:0]   cfg_iv,
    input  logic               cfg_mode,
    simon64_96_cbc_if.slave    bus,
    output logic               keyed,
    output logic [CNT_W-1:0]   blk_cnt
);

    cbc_state_t       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] chain_q, chain_d;
    logic [BLK_W-1:0] core_in_q, core_in_d;
    logic [BLK_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             keyed_q, keyed_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0] core_out;
    logic             in_ready;
    logic             enc;

`ifdef SIMON_CBC_DECRYPT_EN
    logic             mode_q, mode_d;
    logic [BLK_W-1:0] ct_q, ct_d;
    assign enc = mode_q;
`else
    logic unused_cfg_mode;
    assign unused_cfg_mode = cfg_mode;
    assign enc             = MODE_ENC;
`endif

    simon64_96 u_core (
        .block_in         (core_in_q),
        .key              (key_q),
        .encryptOrDecrypt (enc),
        .block_out        (core_out)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        chain_d     = chain_q;
        core_in_d   = core_in_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        keyed_d     = keyed_q;
        blk_cnt_d   = blk_cnt_q;
        in_ready    = 1'b0;
`ifdef SIMON_CBC_DECRYPT_EN
        mode_d      = mode_q;
        ct_d        = ct_q;
`endif
        unique case (state_q)
            UNKEYED, IDLE: begin
                if (cfg_load) begin
                    key_d     = cfg_key;
                    chain_d   = cfg_iv;
                    blk_cnt_d = '0;
                    keyed_d   = 1'b1;
                    state_d   = IDLE;
`ifdef SIMON_CBC_DECRYPT_EN
                    mode_d    = cfg_mode;
`endif
                end else if (state_q == IDLE) begin
                    in_ready = 1'b1;
                    if (bus.in_valid) begin
                        state_d = CALC;
`ifdef SIMON_CBC_DECRYPT_EN
                        core_in_d = (enc == MODE_ENC) ? (bus.in_data ^ chain_q) : bus.in_data;
                        ct_d      = bus.in_data;
`else
                        core_in_d = bus.in_data ^ chain_q;
`endif
                    end
                end
            end
            CALC: begin
`ifdef SIMON_CBC_DECRYPT_EN
                if (enc == MODE_ENC) begin
                    out_data_d = core_out;
                    chain_d    = core_out;
                end else begin
                    out_data_d = core_out ^ chain_q;
                    chain_d    = ct_q;
                end
`else
                out_data_d = core_out;
                chain_d    = core_out;
`endif
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    blk_cnt_d   = blk_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = UNKEYED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNKEYED;
            key_q       <= '0;
            chain_q     <= '0;
            core_in_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            keyed_q     <= 1'b0;
            blk_cnt_q   <= '0;
`ifdef SIMON_CBC_DECRYPT_EN
            mode_q      <= MODE_ENC;
            ct_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            chain_q     <= chain_d;
            core_in_q   <= core_in_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            keyed_q     <= keyed_d;
            blk_cnt_q   <= blk_cnt_d;
`ifdef SIMON_CBC_DECRYPT_EN
            mode_q      <= mode_d;
            ct_q        <= ct_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign keyed         = keyed_q;
    assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_simon64_96_cbc.sv
// Directed bench for simon64_96_cbc; decrypt round trip runs when SIMON_CBC_DECRYPT_EN is defined.
module tb_simon64_96_cbc;
    import simon_cbc_pkg::*;

    localparam logic [95:0] K1    = 96'h131211100b0a090803020100;
    localparam logic [95:0] K2    = 96'hdeadbeef0123456789abcdef;
    localparam logic [63:0] PT    = 64'h6f7220676e696c63;
    localparam logic [63:0] CT    = 64'h5ca2e27f111a8fc8;
    localparam logic [63:0] IV_RT = 64'h0123456789abcdef;
    localparam logic [61:0] Z_REF = 62'b10101111011100000011010010011000101000010001111110010110110011;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        cfg_load = 1'b0;
    logic        cfg_mode = 1'b1;
    logic [95:0] cfg_key  = '0;
    logic [63:0] cfg_iv   = '0;
    logic        keyed;
    logic [15:0] blk_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] chain;
    logic [63:0] expv;
    logic [63:0] got;

    simon64_96_cbc_if bus ();

    simon64_96_cbc #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_load (cfg_load),
        .cfg_key  (cfg_key),
        .cfg_iv   (cfg_iv),
        .cfg_mode (cfg_mode),
        .bus      (bus),
        .keyed    (keyed),
        .blk_cnt  (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [63:0] ref_cipher(input logic [63:0] blk, input logic [95:0] key,
                                               input logic do_enc);
        logic [31:0] k[42];
        logic [31:0] x, y, t;
        k[0] = key[31:0];
        k[1] = key[63:32];
        k[2] = key[95:64];
        for (int i = 3; i < 42; i++) begin
            t    = rol(k[i-1], 29);
            t    = t ^ rol(t, 31);
            k[i] = 32'hfffffffc ^ {31'd0, Z_REF[61-(i-3)]} ^ k[i-3] ^ t;
        end
        x = blk[63:32];
        y = blk[31:0];
        if (do_enc) begin
            for (int i = 0; i < 42; i++) begin
                t = x;
                x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
                y = t;
            end
        end else begin
            for (int i = 41; i >= 0; i--) begin
                t = y;
                y = x ^ (rol(y, 1) & rol(y, 8)) ^ rol(y, 2) ^ k[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [95:0] k, input logic [63:0] iv, input logic mode);
        cfg_key  = k;
        cfg_iv   = iv;
        cfg_mode = mode;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    // Returns just after the accept edge, with the controller in CALC.
    task automatic send(input string tag, input logic [63:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_accept"}, {63'd0, bus.in_ready}, 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [63:0] exp);
        int n = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk(tag, bus.out_data, exp);
        got = bus.out_data;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_keyed", {63'd0, keyed}, 64'd0);
        chk("rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        rst_n = 1'b1;

        // Blocks offered before any key must be refused.
        bus.in_valid = 1'b1;
        bus.in_data  = PT;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("unkeyed_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        chk("unkeyed_keyed", {63'd0, keyed}, 64'd0);

        load_cfg(K1, 64'd0, MODE_ENC);
        chk("cfg_keyed", {63'd0, keyed}, 64'd1);
        chk("cfg_blk_cnt", {48'd0, blk_cnt}, 64'd0);

        // cfg_load wins over a simultaneous block in IDLE.
        bus.in_valid = 1'b1;
        bus.in_data  = PT;
        cfg_load     = 1'b1;
        #1;
        chk("cfg_vs_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        cfg_load     = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("cfg_vs_in_idle", {63'd0, bus.in_ready}, 64'd1);
        chk("cfg_vs_in_cnt", {48'd0, blk_cnt}, 64'd0);
        tick();
        chk("cfg_vs_in_no_out", {63'd0, bus.out_valid}, 64'd0);

        // Single block: two edges from accept to out_valid.
        send("single", PT);
        chk("lat_calc_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("lat_calc_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        chk("lat_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("single_ct", bus.out_data, CT);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("single_handoff", {63'd0, bus.out_valid}, 64'd0);
        chk("single_cnt", {48'd0, blk_cnt}, 64'd1);
        chk("next_accept_ready", {63'd0, bus.in_ready}, 64'd1);
        chain = CT;

        // Same plaintext again must chain off the previous ciphertext.
        send("chain", PT);
        expv = ref_cipher(PT ^ chain, K1, 1'b1);
        recv("chain_ct", expv);
        chk("chain_differs", {63'd0, got != CT}, 64'd1);
        chk("chain_cnt", {48'd0, blk_cnt}, 64'd2);
        chain = expv;

        // Backpressure: hold the result for 10 cycles.
        send("bp", PT);
        expv = ref_cipher(PT ^ chain, K1, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_data", bus.out_data, expv);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_cnt", {48'd0, blk_cnt}, 64'd2);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_handoff", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_cnt_after", {48'd0, blk_cnt}, 64'd3);
        chain = expv;

        // cfg_load during CALC is ignored: old key, old chain, counter keeps going.
        send("calc_cfg", PT);
        cfg_key  = K2;
        cfg_iv   = IV_RT;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        expv = ref_cipher(PT ^ chain, K1, 1'b1);
        recv("calc_cfg_ct", expv);
        chk("calc_cfg_cnt", {48'd0, blk_cnt}, 64'd4);
        chain = expv;
        send("calc_cfg_next", PT);
        expv = ref_cipher(PT ^ chain, K1, 1'b1);
        recv("calc_cfg_next_ct", expv);
        chk("calc_cfg_next_cnt", {48'd0, blk_cnt}, 64'd5);

`ifdef SIMON_CBC_DECRYPT_EN
        begin
            logic [63:0] pts[3];
            logic [63:0] cts[3];
            pts[0] = PT;
            pts[1] = 64'h0011223344556677;
            pts[2] = 64'hfedcba9876543210;
            load_cfg(K1, IV_RT, MODE_ENC);
            chain = IV_RT;
            for (int i = 0; i < 3; i++) begin
                send("rt_enc", pts[i]);
                expv = ref_cipher(pts[i] ^ chain, K1, 1'b1);
                recv("rt_enc_ct", expv);
                cts[i] = got;
                chain  = expv;
            end
            load_cfg(K1, IV_RT, MODE_DEC);
            for (int i = 0; i < 3; i++) begin
                send("rt_dec", cts[i]);
                recv("rt_dec_pt", pts[i]);
            end
            chk("rt_cnt", {48'd0, blk_cnt}, 64'd3);
        end
`else
        // Encrypt-only build ignores a decrypt request.
        load_cfg(K1, 64'd0, MODE_DEC);
        chk("forced_cnt", {48'd0, blk_cnt}, 64'd0);
        send("forced_enc", PT);
        recv("forced_enc_ct", CT);
`endif

        // Asynchronous reset during CALC drops the pending result.
        load_cfg(K1, 64'd0, MODE_ENC);
        send("abort", PT);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_keyed", {63'd0, keyed}, 64'd0);
        chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("abort_cnt", {48'd0, blk_cnt}, 64'd0);
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = PT;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_result", {63'd0, bus.out_valid}, 64'd0);
            chk("abort_needs_key", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        load_cfg(K1, 64'd0, MODE_ENC);
        send("rekey", PT);
        recv("rekey_ct", CT);
        chk("rekey_cnt", {48'd0, blk_cnt}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
